// File: rtl/count_seq_monitor.sv
// Sequence-integrity checker for a 3-bit counter stream: tracks lock, mismatch
// and stall faults against a parameterised successor table.
module count_seq_monitor #(
    parameter logic [23:0] SEQ       = 24'o07654321,
    parameter int          LOCK_CNT  = 4,
    parameter int          STALL_MAX = 3,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       count,
    input  logic             err_clr,
    output logic             locked,
    output logic             fault,
    output logic             err_pulse,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       STALL_C = 4'(STALL_MAX);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q;
    logic [2:0]       prev_q;
    logic [3:0]       match_q;
    logic [3:0]       stall_q;
    logic [ERR_W-1:0] err_q;
    logic             pulse_q;
    logic             stallOut_q;

    logic [4:0]       seqIdx;
    logic [2:0]       expVal;
    logic             isMatch;
    logic             isHold;
    logic [3:0]       stall_d;
    logic             stallHit;
    logic             errEvent;
    logic [3:0]       match_d;

    // A hold only counts as a fault candidate when the table does not expect it.
    always_comb begin
        seqIdx   = 5'(prev_q) * 5'd3;
        expVal   = SEQ[seqIdx +: 3];
        isMatch  = (count == expVal);
        isHold   = !isMatch && (count == prev_q);
        stall_d  = 4'd0;
        if (isHold) begin
            stall_d = (stall_q == STALL_C) ? stall_q : stall_q + 4'd1;
        end
        stallHit = (stall_d == STALL_C);
        errEvent = !isMatch && !isHold && ((state_q == LOCKED) || (state_q == FAULT));
        match_d  = match_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= 3'd0;
            match_q    <= 4'd0;
            stall_q    <= 4'd0;
            err_q      <= '0;
            pulse_q    <= 1'b0;
            stallOut_q <= 1'b0;
        end else begin
            prev_q  <= count;
            pulse_q <= errEvent;

            if (err_clr) begin
                err_q <= '0;
            end else if (errEvent && (err_q != ERR_MAX)) begin
                err_q <= err_q + 1'b1;
            end

            if (state_q == IDLE) begin
                match_q    <= 4'd0;
                stall_q    <= 4'd0;
                stallOut_q <= 1'b0;
                state_q    <= SEARCH;
            end else begin
                stall_q    <= stall_d;
                stallOut_q <= stallHit;
                case (state_q)
                    SEARCH: begin
                        if (isMatch) begin
                            match_q <= match_d;
                            if (match_d >= LOCK_C) begin
                                state_q <= LOCKED;
                            end
                        end else if (!isHold) begin
                            match_q <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (errEvent || (isHold && stallHit)) begin
                            state_q <= FAULT;
                        end
                    end
                    FAULT: begin
                        // Recovery credits the matching transition that ended the fault.
                        if (isMatch) begin
                            match_q <= 4'd1;
                            state_q <= (LOCK_C == 4'd1) ? LOCKED : SEARCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign locked    = (state_q == LOCKED);
    assign fault     = (state_q == FAULT);
    assign state_o   = state_q;
    assign err_pulse = pulse_q;
    assign stall     = stallOut_q;
    assign err_cnt   = err_q;

endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream checker for the 3-bit `count` stream produced by the ROM-based Moore counter FSM. It samples the counter output every clock and compares each new value against an expected-successor table. From that comparison it derives a lock state, mismatch and stall faults, and a saturating error count. The counter and its bench use these results to confirm sequence integrity without waveform inspection.

## Interface
Parameters:
- `SEQ`, default `24'o07654321`: expected-successor table. The successor of value v is `SEQ[3v+2:3v]`. The default encodes a binary up-count that wraps from 7 to 0.
- `LOCK_CNT`, default 4: consecutive correct transitions required to lock (range 1–15).
- `STALL_MAX`, default 3: consecutive hold cycles that constitute a stall (range 1–15).
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset. All state clears immediately on assertion.
- `count` input 3: counter value under test, sampled every rising edge.
- `err_clr` input 1: synchronous clear of `err_cnt`.
- `locked` output 1: state is LOCKED.
- `fault` output 1: state is FAULT.
- `err_pulse` output 1: one-cycle pulse per counted mismatch.
- `stall` output 1: hold run has reached `STALL_MAX`.
- `err_cnt` output ERR_W: saturating mismatch count.
- `state_o` output 2: encoded state: IDLE=0, SEARCH=1, LOCKED=2, FAULT=3.

## Operation
Internal registers:
- `prev` (3b): last sample.
- `match_cnt` (4b).
- `stall_cnt` (4b), saturates at `STALL_MAX`.

Per-edge classification (not evaluated in IDLE), with `exp = SEQ[3*prev +: 3]`:
- MATCH: `count == exp`. MATCH has priority; if `exp == prev`, a hold counts as MATCH.
- HOLD: `count == prev` and not MATCH.
- MISMATCH: neither.

`prev` loads `count` on every edge. `stall_cnt` increments on HOLD and clears on MATCH or MISMATCH.

State transitions:
- **IDLE**: first edge with `reset` low captures `prev`, clears `match_cnt`, goes to SEARCH.
- **SEARCH**:
  - MATCH: `match_cnt+1`. Reaching `LOCK_CNT` goes to LOCKED.
  - HOLD: `match_cnt` unchanged.
  - MISMATCH: `match_cnt = 0`. Not counted as an error.
- **LOCKED**:
  - MATCH: stay.
  - HOLD: stay, unless `stall_cnt` reaches `STALL_MAX` on this edge. In that case go to FAULT; no error is counted.
  - MISMATCH: `err_pulse`, `err_cnt+1`, go to FAULT.
- **FAULT**:
  - MATCH: go to SEARCH with `match_cnt = 1`. If `LOCK_CNT == 1`, go directly to LOCKED.
  - MISMATCH: `err_pulse`, `err_cnt+1`, stay.
  - HOLD: stay.

Error counter:
- `err_cnt` saturates at all ones. At saturation, `err_pulse` still fires.
- `err_clr` wins over a same-edge increment: result is 0. `err_pulse` still fires.

Output decode:
- `stall = (stall_cnt == STALL_MAX)`, registered, in any non-IDLE state.
- `locked`, `fault` and `state_o` are decoded from the state register.

## Timing
- All outputs are registered. Reset value of every output is 0, and state is IDLE.
- `count` is sampled on edge N. Classification results and outputs are visible after edge N; there is no additional pipeline.
- Lock timing: reset deasserts, E0 captures, then E1..E`LOCK_CNT` are MATCH. `locked` rises after E`LOCK_CNT`, i.e. after 4 correct transitions with the defaults.
- `err_pulse` is high exactly one cycle per counted mismatch. Back-to-back mismatches keep it high continuously.
- Reset asserted mid-operation clears all outputs asynchronously, with no edge required. Release restarts from IDLE.
- No handshake. `count` must be stable at the sampling edge, i.e. driven from the same clock domain.

## Test plan
1. **Lock and hold lock.** Reset for 2 cycles, then drive 0,1,2,…,7,0,1 one value per cycle. Required: `locked` = 1 after the 4th MATCH edge, `state_o` = 2, `err_cnt` = 0, `fault` = 0 through the wrap from 7 to 0.
2. **Mismatch and relock.** From locked at `count` = 4, drive 3 instead of 5, then 4,5,6,7. Required:
   - `err_pulse` high for one cycle.
   - `err_cnt` = 1; `fault` = 1 and `locked` = 0 after the mismatch edge.
   - SEARCH after the next MATCH (3 to 4), with `match_cnt` = 1.
   - `locked` = 1 after 3 further MATCHes.
3. **Stall.** Locked, hold `count` = 6 for 2 cycles, then advance: `locked` stays 1 and `stall` = 0. Hold for 3 cycles: `stall` = 1 and `fault` = 1 on the 3rd hold edge, `err_cnt` unchanged.
4. **Saturation and clear.** With `ERR_W` = 2, locked, inject 5 mismatches. Required: `err_cnt` = 3 and 5 `err_pulse` cycles. Assert `err_clr`: `err_cnt` = 0. Assert `err_clr` together with a mismatch: `err_cnt` = 0 and `err_pulse` = 1.
5. **Asynchronous reset.** While locked with `err_cnt` = 2, assert `reset` between clock edges. Required: all outputs = 0 immediately, with no edge required. Release: `locked` = 1 again after E0 plus 4 MATCH edges.
6. **Custom table.** With `SEQ` set to the Gray cycle 0,1,3,2,6,7,5,4, drive that sequence and check the result is identical to scenario 1. Then drive a binary count: the monitor must never lock and must count no errors.
